wired_fpu_arbiter: RTL
======================

// Module: wired_fpu_arbiter
// PURPOSE
//  Shares one fpnew (cvfpu) execution unit between two FPU issue queues: req0 = in-order FPU IQ (FCC/compare ops),
//  req1 = out-of-order FPU IQ. Arbitrates issue, tracks in-flight ops by wid in an owner table, and routes the
//  out-of-order fpnew responses back to the issuing IQ. Handles backend flush. Sits between both FPU IQs and fpnew.
// PARAMETERS
//  MAX_INFLIGHT  4  owner-table entries = max ops inside fpnew at once (2..8)
// PORTS
//  clk            in   1                  clock; single clock domain
//  rst            in   1                  synchronous reset, active-high
//  flush_i        in   1                  backend flush; kills all in-flight ops
//  req_valid_i    in   2                  per-IQ request valid ([0]=in-order IQ, [1]=OOO IQ)
//  req_ready_o    out  2                  per-IQ request accepted
//  req_i          in   2 x iq_fpu_req_t   per-IQ request (op, rnd_mode, mode, r0..r2, wid)
//  resp_valid_o   out  2                  per-IQ response valid
//  resp_ready_i   in   2                  per-IQ response ready (IQ commit FIFO non-full)
//  resp_o         out  iq_fpu_resp_t      response payload, shared by both IQs (qualified by resp_valid_o)
//  ex_valid_o     out  1                  request to fpnew
//  ex_ready_i     in   1                  fpnew accepts
//  ex_req_o       out  iq_fpu_req_t       request payload to fpnew
//  ex_flush_o     out  1                  flush to fpnew
//  ex_valid_i     in   1                  fpnew response valid
//  ex_ready_o     out  1                  response accepted
//  ex_resp_i      in   iq_fpu_resp_t      fpnew response (wid, result, fp_excp)
//  busy_o         out  1                  any op in flight or request held
// BEHAVIOUR
//  Reset (rst=1, sync): owner table all invalid, inflight_cnt=0, rr_ptr=0, FSM=ARB; all outputs 0 except ex_ready_o=1.
//  Issue FSM: ARB: pick requester, zero-latency combinational mux onto ex_req_o. Both valid -> rr_ptr picks,
//    else the only valid one. Handshake (ex_valid_o&ex_ready_i) -> stay ARB, rr_ptr <= ~winner.
//    ex_valid_o & !ex_ready_i -> HOLD. HOLD: owner locked, ex_req_o/ex_valid_o stay stable (IQs hold valid/payload
//    until ready); leave HOLD to ARB on handshake.
//  req_ready_o[i] = grant[i] & ex_ready_i & !full & !flush_i. ex_valid_o = |grant & !full & !flush_i.
//  full = (inflight_cnt == MAX_INFLIGHT), registered; no issue when full even if a response frees a slot that cycle.
//  Allocate on issue handshake: lowest invalid entry <= {wid, owner}; inflight_cnt +1.
//  Response: CAM ex_resp_i.wid against valid entries -> owner; resp_valid_o[owner]=ex_valid_i; resp_o=ex_resp_i;
//    ex_ready_o = resp_ready_i[owner]. On ex_valid_i&ex_ready_o entry invalidated, inflight_cnt -1.
//  Miss (wid not in table: stale op from before flush): ex_ready_o=1, both resp_valid_o=0, response dropped.
//  Same-cycle issue + retire: both applied, inflight_cnt unchanged; retiring entry may not be re-allocated same cycle.
//  Flush: ex_flush_o = flush_i (combinational); on flush_i table cleared, inflight_cnt<=0, FSM<=ARB, rr_ptr kept.
//    Flush wins over simultaneous issue/retire in that cycle. flush_i held several cycles: no issue throughout.
//  Invariant: a wid is never valid twice in the table (ROB ids unique); duplicate is an assertion failure.
//  busy_o = (inflight_cnt != 0) | (FSM==HOLD).
// CONFIGURATION
//  WIRED_FPU_ARB_PERF_EN defined: adds ports perf_grant0_o, perf_grant1_o, perf_full_stall_o (32b each, wrap),
//    counting issue handshakes per IQ and cycles with |req_valid_i & full; cleared by rst only, not by flush.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Package wired0_defines/shared pkg: iq_fpu_req_t, iq_fpu_resp_t, rob_rid_t, fp_excp_t (existing);
//    add fpu_arb_owner_t (1b) and typedef of owner-table entry {valid, wid, owner}.
//  One sub-module: wired_fpu_owner_table (alloc port, CAM lookup/free port, clear, full/count).
// TESTING
//  1 Both IQs valid every cycle, ex_ready_i=1, responses in order -> grants alternate 0,1,0,1; each response to issuer.
//  2 req1 valid, ex_ready_i=0 for 3 cycles, req0 raises valid in cycle 2 -> ex_req_o stays req1 (HOLD) until accept.
//  3 MAX_INFLIGHT=4, issue wids 5,6,7,8, no responses -> 5th request not accepted; wid 7 returns -> issue resumes next cycle.
//  4 Out-of-order return wid 8 (owner 1) then 5 (owner 0) with resp_ready_i[1]=0 -> ex_ready_o=0, stall until ready.
//  5 3 ops in flight, flush_i 1 cycle -> ex_flush_o=1, inflight 0; later stale wid 6 response dropped, no resp_valid_o.
//  6 rst asserted mid-HOLD with 2 in flight -> next cycle all outputs reset values, table empty, rr_ptr=0.

Source files
------------

// File: rtl/wired_fpu_arbiter_pkg.sv
// Shared FPU issue/response types plus arbiter owner-table types.
package wired_fpu_arbiter_pkg;

   typedef logic [5:0] rob_rid_t;

   typedef struct packed {
      logic nv;
      logic dz;
      logic of;
      logic uf;
      logic nx;
   } fp_excp_t;

   typedef struct packed {
      logic [3:0]  op;
      logic [2:0]  rnd_mode;
      logic        mode;
      logic [31:0] r0;
      logic [31:0] r1;
      logic [31:0] r2;
      rob_rid_t    wid;
   } iq_fpu_req_t;

   typedef struct packed {
      rob_rid_t    wid;
      logic [31:0] result;
      fp_excp_t    fp_excp;
   } iq_fpu_resp_t;

   // 0 = in-order FPU IQ, 1 = out-of-order FPU IQ
   typedef logic fpu_arb_owner_t;

   typedef struct packed {
      logic           valid;
      rob_rid_t       wid;
      fpu_arb_owner_t owner;
   } fpu_arb_entry_t;

   typedef enum logic {
      ARB_S  = 1'b0,
      HOLD_S = 1'b1
   } fpu_arb_state_e;

endpackage

// File: rtl/wired_fpu_owner_table.sv
// In-flight op table: allocates lowest free entry, CAM lookup by wid for retire,
// bulk clear on flush, and occupancy count/full.
module wired_fpu_owner_table
   import wired_fpu_arbiter_pkg::*;
#(
   parameter int MAX_INFLIGHT = 4,
   localparam int CNT_W = $clog2(MAX_INFLIGHT + 1),
   localparam int IDX_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear_i,
   input  logic             alloc_en_i,
   input  rob_rid_t         alloc_wid_i,
   input  fpu_arb_owner_t   alloc_owner_i,
   input  rob_rid_t         lookup_wid_i,
   output logic             lookup_hit_o,
   output fpu_arb_owner_t   lookup_owner_o,
   input  logic             free_en_i,
   output logic             full_o,
   output logic [CNT_W-1:0] count_o
);

   fpu_arb_entry_t   entry_q [MAX_INFLIGHT];
   fpu_arb_entry_t   entry_d [MAX_INFLIGHT];
   logic [CNT_W-1:0] count_q, count_d;
   logic [IDX_W-1:0] hit_idx, alloc_idx;
   logic             alloc_found, dup_wid;

   always_comb begin
      lookup_hit_o   = 1'b0;
      lookup_owner_o = 1'b0;
      hit_idx        = '0;
      alloc_found    = 1'b0;
      alloc_idx      = '0;
      for (int i = 0; i < MAX_INFLIGHT; i++) begin
         if (entry_q[i].valid && entry_q[i].wid == lookup_wid_i) begin
            lookup_hit_o   = 1'b1;
            lookup_owner_o = entry_q[i].owner;
            hit_idx        = IDX_W'(i);
         end
      end
      // Scan from the top so the last hit is the lowest free index.
      for (int i = MAX_INFLIGHT - 1; i >= 0; i--) begin
         if (!entry_q[i].valid) begin
            alloc_found = 1'b1;
            alloc_idx   = IDX_W'(i);
         end
      end
      dup_wid = 1'b0;
      for (int i = 0; i < MAX_INFLIGHT; i++) begin
         if (entry_q[i].valid && entry_q[i].wid == alloc_wid_i &&
             !(free_en_i && lookup_hit_o && hit_idx == IDX_W'(i)))
            dup_wid = 1'b1;
      end
   end

   always_comb begin
      entry_d = entry_q;
      count_d = count_q;
      if (free_en_i && lookup_hit_o) begin
         entry_d[hit_idx].valid = 1'b0;
         count_d = count_d - CNT_W'(1);
      end
      if (alloc_en_i && alloc_found) begin
         entry_d[alloc_idx] = '{valid: 1'b1, wid: alloc_wid_i, owner: alloc_owner_i};
         count_d = count_d + CNT_W'(1);
      end
      if (clear_i) begin
         for (int i = 0; i < MAX_INFLIGHT; i++) entry_d[i].valid = 1'b0;
         count_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         entry_q <= '{default: '0};
         count_q <= '0;
      end else begin
         entry_q <= entry_d;
         count_q <= count_d;
      end
   end

   assign full_o  = (count_q == CNT_W'(MAX_INFLIGHT));
   assign count_o = count_q;

   // ROB ids are unique, so an allocating wid must never already be live.
   a_no_dup_wid: assert property (@(posedge clk) disable iff (rst)
      (alloc_en_i && !clear_i) |-> !dup_wid);

endmodule

// File: rtl/wired_fpu_arbiter.sv
// Shares one fpnew unit between the in-order and out-of-order FPU IQs and routes
// responses back by wid. Optional perf counters: define WIRED_FPU_ARB_PERF_EN.
//   state  | meaning
//   ARB_S  | pick a requester each cycle, round-robin when both are valid
//   HOLD_S | fpnew stalled an offered op; owner and payload locked until accepted
module wired_fpu_arbiter
   import wired_fpu_arbiter_pkg::*;
#(
   parameter int MAX_INFLIGHT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush_i,
   input  logic [1:0]        req_valid_i,
   output logic [1:0]        req_ready_o,
   input  iq_fpu_req_t [1:0] req_i,
   output logic [1:0]        resp_valid_o,
   input  logic [1:0]        resp_ready_i,
   output iq_fpu_resp_t      resp_o,
   output logic              ex_valid_o,
   input  logic              ex_ready_i,
   output iq_fpu_req_t       ex_req_o,
   output logic              ex_flush_o,
   input  logic              ex_valid_i,
   output logic              ex_ready_o,
   input  iq_fpu_resp_t      ex_resp_i,
   output logic              busy_o
`ifdef WIRED_FPU_ARB_PERF_EN
   ,
   output logic [31:0]       perf_grant0_o,
   output logic [31:0]       perf_grant1_o,
   output logic [31:0]       perf_full_stall_o
`endif
);

   localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

   fpu_arb_state_e   state_q, state_d;
   fpu_arb_owner_t   rr_ptr_q, rr_ptr_d;
   fpu_arb_owner_t   hold_owner_q, hold_owner_d;
   fpu_arb_owner_t   winner, resp_owner;
   logic             any_req, issue_ok, issue_fire, full, resp_hit, retire;
   logic [CNT_W-1:0] inflight_cnt;

   always_comb begin
      if (state_q == HOLD_S) begin
         winner  = hold_owner_q;
         any_req = req_valid_i[hold_owner_q];
      end else begin
         any_req = |req_valid_i;
         if (req_valid_i == 2'b01)      winner = 1'b0;
         else if (req_valid_i == 2'b10) winner = 1'b1;
         else                           winner = rr_ptr_q;
      end
      issue_ok   = any_req & ~full & ~flush_i;
      issue_fire = issue_ok & ex_ready_i;
      ex_valid_o = issue_ok;
      ex_req_o   = issue_ok ? req_i[winner] : '0;
      req_ready_o         = '0;
      req_ready_o[winner] = issue_fire;

      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      hold_owner_d = hold_owner_q;
      case (state_q)
         ARB_S: begin
            if (issue_fire) begin
               rr_ptr_d = ~winner;
            end else if (issue_ok) begin
               state_d      = HOLD_S;
               hold_owner_d = winner;
            end
         end
         HOLD_S: begin
            if (issue_fire) begin
               state_d  = ARB_S;
               rr_ptr_d = ~winner;
            end
         end
         default: state_d = ARB_S;
      endcase
      if (flush_i) state_d = ARB_S;
   end

   always_comb begin
      resp_valid_o = '0;
      ex_ready_o   = 1'b1;
      // A miss is a stale op from before a flush: accept and drop it.
      if (resp_hit) begin
         resp_valid_o[resp_owner] = ex_valid_i;
         ex_ready_o               = resp_ready_i[resp_owner];
      end
      retire = ex_valid_i & ex_ready_o & resp_hit;
   end

   assign resp_o     = ex_resp_i;
   assign ex_flush_o = flush_i;
   assign busy_o     = (inflight_cnt != '0) | (state_q == HOLD_S);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ARB_S;
         rr_ptr_q     <= 1'b0;
         hold_owner_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         hold_owner_q <= hold_owner_d;
      end
   end

   wired_fpu_owner_table #(
      .MAX_INFLIGHT (MAX_INFLIGHT)
   ) u_owner_table (
      .clk            (clk),
      .rst            (rst),
      .clear_i        (flush_i),
      .alloc_en_i     (issue_fire),
      .alloc_wid_i    (ex_req_o.wid),
      .alloc_owner_i  (winner),
      .lookup_wid_i   (ex_resp_i.wid),
      .lookup_hit_o   (resp_hit),
      .lookup_owner_o (resp_owner),
      .free_en_i      (retire),
      .full_o         (full),
      .count_o        (inflight_cnt)
   );

`ifdef WIRED_FPU_ARB_PERF_EN
   logic [31:0] perf_grant0_q, perf_grant1_q, perf_full_stall_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_grant0_q     <= '0;
         perf_grant1_q     <= '0;
         perf_full_stall_q <= '0;
      end else begin
         if (issue_fire && !winner)      perf_grant0_q     <= perf_grant0_q + 32'd1;
         if (issue_fire && winner)       perf_grant1_q     <= perf_grant1_q + 32'd1;
         if ((|req_valid_i) && full)     perf_full_stall_q <= perf_full_stall_q + 32'd1;
      end
   end

   assign perf_grant0_o     = perf_grant0_q;
   assign perf_grant1_o     = perf_grant1_q;
   assign perf_full_stall_o = perf_full_stall_q;
`endif

endmodule
